// File: rtl/ehl_gpio_irq.sv
// GPIO interrupt status block: per-line level/edge event detection into a
// sticky write-1-to-clear status register, with a registered combined request.
module ehl_gpio_irq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] ier,
  input  logic [WIDTH-1:0] itr,
  input  logic [WIDTH-1:0] ipr,
  input  logic [WIDTH-1:0] ibe,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_data,
  output logic [WIDTH-1:0] isr,
  output logic             irq
);

  logic [WIDTH-1:0] prev;
  logic             primed;
  logic [WIDTH-1:0] lvl_ev;
  logic [WIDTH-1:0] edg_ev;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] isr_nxt;

  always_comb begin
    // Active level is din==1 for ipr=0 and din==0 for ipr=1, i.e. din ^ ipr.
    lvl_ev   = ~itr & (din ^ ipr);
    // primed gates every edge term so the first post-reset sample of din,
    // compared against the reset value of prev, can never look like an edge.
    edg_ev   = {WIDTH{primed}} & itr &
               ((ibe & (prev ^ din)) |
                (~ibe & ~ipr & ~prev &  din) |
                (~ibe &  ipr &  prev & ~din));
    set_mask = (lvl_ev | edg_ev) & ier;
    clr_mask = {WIDTH{clr_en}} & clr_data;
    // Set takes priority over clear, so an active level cannot be cleared.
    isr_nxt  = set_mask | (isr & ~clr_mask);
  end

  // NOTE: state is updated with non-blocking assignments so irq samples the
  // pre-edge isr value, giving the one-cycle isr-to-irq latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev   <= '0;
      primed <= 1'b0;
      isr    <= '0;
      irq    <= 1'b0;
    end else begin
      prev   <= din;
      primed <= 1'b1;
      isr    <= isr_nxt;
      irq    <= |(isr & ier);
    end
  end

endmodule

// File: tb/tb_ehl_gpio_irq.sv
// Self-checking bench for ehl_gpio_irq: directed vector table, hand-written
// reset sequences, and randomized traffic against a per-line reference model.
module tb_ehl_gpio_irq;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] din, ier, itr, ipr, ibe, clr_data;
  logic         clr_en;
  logic [W-1:0] isr;
  logic         irq;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [W-1:0] m_isr, m_prev;
  logic         m_irq, m_primed;

  typedef struct {
    logic [W-1:0] din, ier, itr, ipr, ibe;
    logic         clr_en;
    logic [W-1:0] clr_data;
    logic [W-1:0] exp_isr;
    logic         exp_irq;
  } vec_t;

  vec_t vecs[26];

  ehl_gpio_irq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (din),
    .ier      (ier),
    .itr      (itr),
    .ipr      (ipr),
    .ibe      (ibe),
    .clr_en   (clr_en),
    .clr_data (clr_data),
    .isr      (isr),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] d, input logic [W-1:0] e, input logic [W-1:0] t,
                              input logic [W-1:0] p, input logic [W-1:0] b, input logic c,
                              input logic [W-1:0] cd, input logic [W-1:0] xi, input logic xq);
    vec_t v;
    v.din = d; v.ier = e; v.itr = t; v.ipr = p; v.ibe = b;
    v.clr_en = c; v.clr_data = cd; v.exp_isr = xi; v.exp_irq = xq;
    return v;
  endfunction

  task automatic model_reset();
    m_isr = '0; m_irq = 1'b0; m_prev = '0; m_primed = 1'b0;
  endtask

  // Behavioural rules applied line by line, using the inputs currently driven.
  task automatic model_edge();
    logic [W-1:0] nisr;
    logic         hit;
    m_irq = 1'b0;
    for (int i = 0; i < W; i++) if (m_isr[i] && ier[i]) m_irq = 1'b1;
    nisr = m_isr;
    for (int i = 0; i < W; i++) begin
      if (!itr[i])          hit = ipr[i] ? (din[i] == 1'b0) : (din[i] == 1'b1);
      else if (!m_primed)   hit = 1'b0;
      else if (ibe[i])      hit = (m_prev[i] != din[i]);
      else if (ipr[i])      hit = (m_prev[i] == 1'b1) && (din[i] == 1'b0);
      else                  hit = (m_prev[i] == 1'b0) && (din[i] == 1'b1);
      if (hit && ier[i])                nisr[i] = 1'b1;
      else if (clr_en && clr_data[i])   nisr[i] = 1'b0;
    end
    m_isr    = nisr;
    m_prev   = din;
    m_primed = 1'b1;
  endtask

  // One clock edge: advance the model, then sample the DUT 1 time unit later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [W-1:0] e, input logic [W-1:0] t,
                         input logic [W-1:0] p, input logic [W-1:0] b);
    ier = e; itr = t; ipr = p; ibe = b;
  endtask

  initial begin
    // Directed table, starting from isr=0, prev=all-ones, primed=1.
    vecs[0]  = mk(32'h0,  32'h8,  32'h8,  32'h0,  32'h0,  1'b0, 32'h0,  32'h0,  1'b0);
    vecs[1]  = mk(32'h8,  32'h8,  32'h8,  32'h0,  32'h0,  1'b0, 32'h0,  32'h8,  1'b0);
    vecs[2]  = mk(32'h8,  32'h8,  32'h8,  32'h0,  32'h0,  1'b0, 32'h0,  32'h8,  1'b1);
    vecs[3]  = mk(32'h8,  32'h8,  32'h8,  32'h0,  32'h0,  1'b1, 32'h8,  32'h0,  1'b1);
    vecs[4]  = mk(32'h8,  32'h8,  32'h8,  32'h0,  32'h0,  1'b0, 32'h0,  32'h0,  1'b0);
    vecs[5]  = mk(32'h0,  32'h1,  32'h0,  32'h1,  32'h0,  1'b0, 32'h0,  32'h1,  1'b0);
    vecs[6]  = mk(32'h0,  32'h1,  32'h0,  32'h1,  32'h0,  1'b0, 32'h0,  32'h1,  1'b1);
    vecs[7]  = mk(32'h0,  32'h1,  32'h0,  32'h1,  32'h0,  1'b1, 32'h1,  32'h1,  1'b1);
    vecs[8]  = mk(32'h1,  32'h1,  32'h0,  32'h1,  32'h0,  1'b0, 32'h0,  32'h1,  1'b1);
    vecs[9]  = mk(32'h1,  32'h1,  32'h0,  32'h1,  32'h0,  1'b1, 32'h1,  32'h0,  1'b1);
    vecs[10] = mk(32'h1,  32'h1,  32'h0,  32'h1,  32'h0,  1'b0, 32'h0,  32'h0,  1'b0);
    vecs[11] = mk(32'h1,  32'h20, 32'h20, 32'h20, 32'h20, 1'b0, 32'h0,  32'h0,  1'b0);
    vecs[12] = mk(32'h21, 32'h20, 32'h20, 32'h20, 32'h20, 1'b0, 32'h0,  32'h20, 1'b0);
    vecs[13] = mk(32'h21, 32'h20, 32'h20, 32'h20, 32'h20, 1'b1, 32'h20, 32'h0,  1'b1);
    vecs[14] = mk(32'h1,  32'h20, 32'h20, 32'h20, 32'h20, 1'b0, 32'h0,  32'h20, 1'b0);
    vecs[15] = mk(32'h1,  32'h20, 32'h20, 32'h20, 32'h20, 1'b1, 32'h20, 32'h0,  1'b1);
    vecs[16] = mk(32'h1,  32'h20, 32'h20, 32'h20, 32'h20, 1'b0, 32'h0,  32'h0,  1'b0);
    vecs[17] = mk(32'h81, 32'h80, 32'h80, 32'h0,  32'h0,  1'b1, 32'h80, 32'h80, 1'b0);
    vecs[18] = mk(32'h81, 32'h80, 32'h80, 32'h0,  32'h0,  1'b0, 32'h0,  32'h80, 1'b1);
    vecs[19] = mk(32'h85, 32'h84, 32'h80, 32'h0,  32'h0,  1'b0, 32'h0,  32'h84, 1'b1);
    vecs[20] = mk(32'h81, 32'h84, 32'h80, 32'h0,  32'h0,  1'b1, 32'h80, 32'h04, 1'b1);
    vecs[21] = mk(32'h81, 32'h0,  32'h80, 32'h0,  32'h0,  1'b0, 32'h0,  32'h04, 1'b0);
    vecs[22] = mk(32'h81, 32'h04, 32'h80, 32'h0,  32'h0,  1'b0, 32'h0,  32'h04, 1'b1);
    vecs[23] = mk(32'h81, 32'h04, 32'h80, 32'h04, 32'h0,  1'b1, 32'h04, 32'h04, 1'b1);
    vecs[24] = mk(32'h81, 32'h04, 32'h80, 32'h0,  32'h0,  1'b1, 32'h04, 32'h0,  1'b1);
    vecs[25] = mk(32'h81, 32'h04, 32'h80, 32'h0,  32'h0,  1'b0, 32'h0,  32'h0,  1'b0);

    // Reset with all lines high and rising-edge config everywhere.
    reset_n = 1'b0;
    din = '1; set_cfg('1, '1, '0, '0);
    clr_en = 1'b0; clr_data = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset isr", isr, '0);
    check("reset irq", {31'b0, irq}, '0);
    reset_n = 1'b1;
    step();
    check("prime edge isr", isr, m_isr);
    check("prime edge isr zero", isr, '0);
    step();
    check("high at release isr", isr, '0);
    check("high at release irq", {31'b0, irq}, '0);

    for (int i = 0; i < 26; i++) begin
      din = vecs[i].din;
      set_cfg(vecs[i].ier, vecs[i].itr, vecs[i].ipr, vecs[i].ibe);
      clr_en = vecs[i].clr_en; clr_data = vecs[i].clr_data;
      step();
      check($sformatf("vec%0d isr", i), isr, vecs[i].exp_isr);
      check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Async reset while irq is high.
    clr_en = 1'b0; clr_data = '0;
    din = 32'h1; set_cfg(32'h1, '0, '0, '0);
    step(); step();
    check("pre-reset irq", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset isr", isr, '0);
    check("async reset irq", {31'b0, irq}, '0);
    model_reset();
    din = '0; set_cfg('1, '1, '0, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    // din jumps 0->1 before the first edge; primed=0 must suppress it.
    din = '1;
    step();
    check("no edge on prime isr", isr, '0);
    step();
    check("no edge after prime isr", isr, '0);
    check("no edge after prime irq", {31'b0, irq}, '0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0)
        set_cfg($urandom(), $urandom(), $urandom(), $urandom());
      din = din ^ ($urandom() & $urandom() & $urandom());
      clr_en = ($urandom_range(0, 3) == 0);
      clr_data = $urandom();
      if ($urandom_range(0, 99) == 0) begin
        #1 reset_n = 1'b0;
        #1;
        check("rand async reset isr", isr, '0);
        check("rand async reset irq", {31'b0, irq}, '0);
        model_reset();
        reset_n = 1'b1;
      end
      step();
      check($sformatf("rand%0d isr", n), isr, m_isr);
      check($sformatf("rand%0d irq", n), {31'b0, irq}, {31'b0, m_irq});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ehl_gpio_irq.md
EHL_GPIO_IRQ -- requirements
Module: ehl_gpio_irq

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the number of GPIO lines handled.
REQ-002 clk  input  1  single clock for all state; every flop SHALL be rising-edge triggered on clk.
REQ-003 reset_n  input  1  reset, asynchronous assert and active-low; it SHALL clear all state.
REQ-004 din  input  WIDTH  filtered/synchronized GPIO levels from the GPIO filter stage, already in the clk domain.
REQ-005 ier  input  WIDTH  per-line interrupt enable; 1 = event may set status.
REQ-006 itr  input  WIDTH  per-line trigger type; 0 = level, 1 = edge.
REQ-007 ipr  input  WIDTH  per-line polarity; 0 = high level / rising edge, 1 = low level / falling edge.
REQ-008 ibe  input  WIDTH  per-line both-edges; 1 with itr=1 = any transition, ipr ignored; no effect when itr=0.
REQ-009 clr_en  input  1  status clear strobe; one-cycle write-1-to-clear.
REQ-010 clr_data  input  WIDTH  clear mask; bit i=1 with clr_en=1 clears isr[i].
REQ-011 isr  output  WIDTH  sticky per-line interrupt status, registered.
REQ-012 irq  output  1  combined interrupt request, registered.

Function
REQ-013 The block SHALL keep a registered copy prev of din, loaded with din on every clock edge after reset.
REQ-014 The block SHALL keep a 1-bit primed flag: 0 at reset, 1 from the first clock edge after reset release onward.
REQ-015 Per line i, ev[i] SHALL be the combinational OR of the following terms:
- level high: itr=0, ipr=0, din=1
- level low: itr=0, ipr=1, din=0
- rising: itr=1, ibe=0, ipr=0, primed=1, prev=0, din=1
- falling: itr=1, ibe=0, ipr=1, primed=1, prev=1, din=0
- any edge: itr=1, ibe=1, primed=1, prev!=din
REQ-016 On each clock edge, isr[i] SHALL set to 1 if ev[i]&ier[i]; else clear to 0 if clr_en&clr_data[i]; else hold.
REQ-017 Set and clear on the same edge SHALL resolve as set wins; a level-type line with its level still active cannot be cleared.
REQ-018 Deasserting ier[i] SHALL NOT clear isr[i]; it only blocks new sets for that line.
REQ-019 No edge SHALL be detected on the first edge after reset release (primed=0), whatever din is.
REQ-020 Latency:
- din transition sampled on edge k sets isr on edge k.
- isr set on edge k drives irq high on edge k+1.
REQ-021 irq SHALL be registered as |(isr & ier), sampled from the isr value before the edge.
REQ-022 Changing itr/ipr/ibe mid-operation SHALL take effect on the next edge; existing isr bits SHALL be retained.
REQ-023 Each line SHALL be independent; no priority or arbitration between lines.
REQ-024 Edges shorter than one clk period are out of scope; the upstream filter guarantees din is clk-synchronous.

Reset
REQ-025 While reset_n=0: isr=0, irq=0, prev=0, primed=0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL drop isr and irq asynchronously.
REQ-027 After release, the first edge loads prev and primed only.
REQ-028 A line already high at reset release SHALL NOT raise a rising-edge interrupt.

Verification
REQ-029 Rising edge, line 3, ier=0x8, itr=0x8, ipr=0: din[3] 0->1 -> isr=0x8 same edge, irq=1 next edge; clr_en=1, clr_data=0x8 -> isr=0, irq=0 one edge later.
REQ-030 Level-low, line 0, itr=0, ipr=1, din[0]=0 held: clr_en pulse on line 0 -> isr[0] stays 1, irq stays 1; set din[0]=1 then clear -> isr[0]=0.
REQ-031 Both edges, line 5, ibe=1, itr=1: din[5] 0->1->0 with clears between -> isr[5] sets twice.
REQ-032 Set/clear collision: edge event on line 7 with clr_en=1, clr_data=0x80 on the same edge -> isr[7]=1.
REQ-033 Masking, isr[2]=1: ier[2] 1->0 -> isr[2] stays 1, irq=0 after one edge; ier[2] 0->1 -> irq=1 after one edge.
REQ-034 Reset priming: din=all-ones through reset release, rising-edge config on all lines -> isr stays 0; async reset pulse while irq=1 -> isr=0 and irq=0 immediately.
